// File: rtl/midi_note_parser_if.sv
// Message stream between the MIDI note parser and the pattern/light-control stage.
// The parser drives the head-of-FIFO fields and valid; the consumer drives ready.
interface midi_note_parser_if;
  logic [7:0] oMsgStatus;
  logic [7:0] oMsgNote;
  logic [7:0] oMsgVelocity;
  logic       oMsgValid;
  logic       iMsgReady;

  modport master (
    output oMsgStatus,
    output oMsgNote,
    output oMsgVelocity,
    output oMsgValid,
    input  iMsgReady
  );

  modport slave (
    input  oMsgStatus,
    input  oMsgNote,
    input  oMsgVelocity,
    input  oMsgValid,
    output iMsgReady
  );
endinterface

// File: rtl/midi_note_parser.sv
// MIDI note parser: turns the raw UART byte stream into Note-On/Note-Off messages,
// honouring running status and realtime bytes, and queues them in a small FIFO
// whose head is presented as registered outputs with a valid/ready handshake.
module midi_note_parser #(
  parameter int          pDepthBits   = 2,
  parameter logic [15:0] pChannelMask = 16'hFFFF,
  parameter bit          pVel0IsOff   = 1'b1
) (
  input  logic               gClock,
  input  logic               gReset,
  input  logic [7:0]         iByte,
  input  logic               iByteValid,
  midi_note_parser_if.master msg,
  output logic               oOverflow,
  output logic               oRunning
);

  localparam int                  cDepth    = 1 << pDepthBits;
  localparam logic [pDepthBits:0] cDepthCnt = (pDepthBits + 1)'(cDepth);
  localparam logic [pDepthBits:0] cOne      = (pDepthBits + 1)'(1);

  typedef enum logic [1:0] {IDLE, DATA1, DATA2, SKIP} state_t;

  state_t     rState;
  logic [7:0] rRun;
  logic [7:0] rNote;

  // Byte classification; realtime bytes (F8-FF) are invisible to the parser.
  logic isRealtime;
  logic isStatus;
  logic isData;
  logic isNoteStatus;
  logic chanOk;

  assign isRealtime   = (iByte[7:3] == 5'b11111);
  assign isStatus     = iByteValid & iByte[7] & ~isRealtime;
  assign isData       = iByteValid & ~iByte[7];
  assign isNoteStatus = (iByte[7:5] == 3'b100);
  assign chanOk       = pChannelMask[iByte[3:0]];

  // A message completes on the velocity byte; Note-On with velocity 0 may be rewritten as Note-Off.
  logic        msgPush;
  logic [7:0]  pushStatus;
  logic [23:0] pushData;

  assign msgPush    = isData & (rState == DATA2);
  assign pushStatus = (pVel0IsOff && rRun[7:4] == 4'h9 && iByte == 8'h00) ? {4'h8, rRun[3:0]} : rRun;
  assign pushData   = {pushStatus, rNote, iByte};

  // Parser FSM: status bytes always restart or abort; data bytes advance only in DATA1/DATA2.
  always_ff @(posedge gClock or negedge gReset) begin
    if (!gReset) begin
      rState   <= IDLE;
      rRun     <= 8'h00;
      rNote    <= 8'h00;
      oRunning <= 1'b0;
    end else if (isStatus) begin
      if (isNoteStatus && chanOk) begin
        rRun     <= iByte;
        oRunning <= 1'b1;
        rState   <= DATA1;
      end else begin
        rRun     <= 8'h00;
        oRunning <= 1'b0;
        rState   <= SKIP;
      end
    end else if (isData) begin
      case (rState)
        DATA1:   begin
          rNote  <= iByte;
          rState <= DATA2;
        end
        DATA2:   rState <= DATA1;
        default: rState <= rState;
      endcase
    end
  end

  // FIFO bookkeeping; pointers carry one extra bit so full and empty are distinguishable.
  logic [23:0]         rMem [cDepth];
  logic [pDepthBits:0] rWrPtr;
  logic [pDepthBits:0] rRdPtr;
  logic [pDepthBits:0] count;
  logic [pDepthBits:0] nextRd;
  logic                full;
  logic                pop;
  logic                doPush;

  assign count  = rWrPtr - rRdPtr;
  assign nextRd = rRdPtr + cOne;
  assign full   = (count == cDepthCnt);
  assign pop    = msg.oMsgValid & msg.iMsgReady;
  assign doPush = msgPush & (~full | pop);

  // Storage array; a simultaneous pop frees the head slot, so a full FIFO can still accept.
  always_ff @(posedge gClock) begin
    if (doPush) begin
      rMem[rWrPtr[pDepthBits-1:0]] <= pushData;
    end
  end

  // Pointers, sticky overflow and the registered head-of-FIFO outputs.
  always_ff @(posedge gClock or negedge gReset) begin
    if (!gReset) begin
      rWrPtr           <= '0;
      rRdPtr           <= '0;
      oOverflow        <= 1'b0;
      msg.oMsgValid    <= 1'b0;
      msg.oMsgStatus   <= 8'h00;
      msg.oMsgNote     <= 8'h00;
      msg.oMsgVelocity <= 8'h00;
    end else begin
      if (doPush) begin
        rWrPtr <= rWrPtr + cOne;
      end
      if (pop) begin
        rRdPtr <= nextRd;
      end
      if (msgPush && full && !pop) begin
        oOverflow <= 1'b1;
      end
      if (pop) begin
        if (count > cOne) begin
          {msg.oMsgStatus, msg.oMsgNote, msg.oMsgVelocity} <= rMem[nextRd[pDepthBits-1:0]];
          msg.oMsgValid <= 1'b1;
        end else if (doPush) begin
          {msg.oMsgStatus, msg.oMsgNote, msg.oMsgVelocity} <= pushData;
          msg.oMsgValid <= 1'b1;
        end else begin
          {msg.oMsgStatus, msg.oMsgNote, msg.oMsgVelocity} <= 24'h000000;
          msg.oMsgValid <= 1'b0;
        end
      end else if (!msg.oMsgValid && doPush) begin
        {msg.oMsgStatus, msg.oMsgNote, msg.oMsgVelocity} <= pushData;
        msg.oMsgValid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_midi_note_parser.sv
// Self-checking bench for midi_note_parser: directed scenarios plus randomized byte
// streams, compared against a message-level model of the MIDI parsing rules.
module tb_midi_note_parser;
  localparam logic [15:0] cMask  = 16'hFFFD;  // channel 1 is filtered out
  localparam int          cDepth = 4;

  logic       gClock = 1'b0;
  logic       gReset = 1'b0;
  logic [7:0] iByte = 8'h00;
  logic       iByteValid = 1'b0;
  logic       oOverflow;
  logic       oRunning;

  midi_note_parser_if msgIf ();

  midi_note_parser #(.pDepthBits(2), .pChannelMask(cMask), .pVel0IsOff(1'b1)) dut (
    .gClock     (gClock),
    .gReset     (gReset),
    .iByte      (iByte),
    .iByteValid (iByteValid),
    .msg        (msgIf.master),
    .oOverflow  (oOverflow),
    .oRunning   (oRunning)
  );

  always #5 gClock = ~gClock;

  int checks = 0;
  int failures = 0;

  // Reference model: running status (-1 = none), how many data bytes of the current message seen.
  int          mRun = -1;
  int          mHave = 0;
  int          mNote = 0;
  bit          mOvf = 1'b0;
  logic [23:0] expQ[$];
  logic [7:0]  stim[$];

  function automatic void modelReset();
    mRun = -1; mHave = 0; mNote = 0; mOvf = 1'b0;
    expQ.delete();
  endfunction

  function automatic void modelByte(input logic [7:0] b);
    int v;
    int st;
    int chan;
    v = int'(b);
    if (v >= 248) return;
    if (v >= 128) begin
      chan = v % 16;
      if ((v / 16 == 8 || v / 16 == 9) && cMask[chan]) begin
        mRun = v; mHave = 0;
      end else begin
        mRun = -1;
      end
    end else if (mRun >= 0) begin
      if (mHave == 0) begin
        mNote = v; mHave = 1;
      end else begin
        st = mRun;
        if (st / 16 == 9 && v == 0) st = 128 + st % 16;
        if (expQ.size() < cDepth) expQ.push_back({8'(st), 8'(mNote), 8'(v)});
        else mOvf = 1'b1;
        mHave = 0;
      end
    end
  endfunction

  task automatic sendStim();
    foreach (stim[i]) begin
      @(negedge gClock);
      iByte = stim[i]; iByteValid = 1'b1;
      modelByte(stim[i]);
    end
    @(negedge gClock);
    iByteValid = 1'b0; iByte = 8'h00;
    stim.delete();
  endtask

  task automatic drainCheck(input string name);
    logic [23:0] act;
    logic [23:0] exp;
    msgIf.iMsgReady = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (msgIf.oMsgValid) begin
        act = {msgIf.oMsgStatus, msgIf.oMsgNote, msgIf.oMsgVelocity};
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("FAIL %s_unexpected got=%06h required=none", name, act);
        end else begin
          exp = expQ.pop_front();
          if (act !== exp) begin
            failures++;
            $display("FAIL %s_msg got=%06h required=%06h", name, act, exp);
          end
        end
      end
      @(negedge gClock);
    end
    msgIf.iMsgReady = 1'b0;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL %s_missing got=%0d_left required=0", name, expQ.size());
      expQ.delete();
    end
    checks++;
    if (msgIf.oMsgValid !== 1'b0) begin
      failures++;
      $display("FAIL %s_empty got=%b required=0", name, msgIf.oMsgValid);
    end
    $display("drain %s done", name);
  endtask

  task automatic test_reset();
    gReset = 1'b0;
    repeat (3) @(negedge gClock);
    checks++;
    if ({msgIf.oMsgValid, oOverflow, oRunning, msgIf.oMsgStatus, msgIf.oMsgNote, msgIf.oMsgVelocity} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b_%02h%02h%02h required=all_zero", msgIf.oMsgValid, oOverflow,
               oRunning, msgIf.oMsgStatus, msgIf.oMsgNote, msgIf.oMsgVelocity);
    end
    gReset = 1'b1;
    modelReset();
    $display("reset checked");
  endtask

  task automatic test_basic();
    stim = '{8'h90, 8'h3C};
    sendStim();
    checks++;
    if (msgIf.oMsgValid !== 1'b0) begin
      failures++; $display("FAIL basic_partial_valid got=%b required=0", msgIf.oMsgValid);
    end
    stim = '{8'h64};
    sendStim();
    checks++;
    if (msgIf.oMsgValid !== 1'b1) begin
      failures++; $display("FAIL basic_latency got=%b required=1", msgIf.oMsgValid);
    end
    checks++;
    if ({msgIf.oMsgStatus, msgIf.oMsgNote, msgIf.oMsgVelocity} !== 24'h903C64) begin
      failures++;
      $display("FAIL basic_head got=%02h%02h%02h required=903c64", msgIf.oMsgStatus, msgIf.oMsgNote, msgIf.oMsgVelocity);
    end
    drainCheck("basic");
  endtask

  task automatic test_running();
    stim = '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h50};
    sendStim();
    checks++;
    if (oRunning !== 1'b1) begin
      failures++; $display("FAIL running_flag got=%b required=1", oRunning);
    end
    drainCheck("running");
  endtask

  task automatic test_realtime_vel0();
    stim = '{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64};
    sendStim();
    drainCheck("realtime");
    stim = '{8'h93, 8'h30, 8'h00};
    sendStim();
    checks++;
    if ({msgIf.oMsgStatus, msgIf.oMsgNote, msgIf.oMsgVelocity} !== 24'h833000) begin
      failures++;
      $display("FAIL vel0_head got=%02h%02h%02h required=833000", msgIf.oMsgStatus, msgIf.oMsgNote, msgIf.oMsgVelocity);
    end
    drainCheck("vel0");
  endtask

  task automatic test_abort_skip();
    stim = '{8'h90, 8'h3C, 8'hB0, 8'h07, 8'h7F, 8'h45};
    sendStim();
    drainCheck("abort");
    stim = '{8'h90, 8'hF0, 8'h01, 8'h02, 8'hF7, 8'h40, 8'h50};
    sendStim();
    checks++;
    if (oRunning !== 1'b0) begin
      failures++; $display("FAIL sysex_running got=%b required=0", oRunning);
    end
    drainCheck("sysex");
    stim = '{8'h91, 8'h3C, 8'h64, 8'h40, 8'h50};
    sendStim();
    drainCheck("masked");
  endtask

  task automatic test_overflow();
    for (int m = 0; m < 5; m++) begin
      stim.push_back(8'h90); stim.push_back(8'(8'h20 + m)); stim.push_back(8'(8'h10 + m));
    end
    sendStim();
    repeat (2) @(negedge gClock);
    checks++;
    if (oOverflow !== 1'b1) begin
      failures++; $display("FAIL overflow_flag got=%b required=1", oOverflow);
    end
    checks++;
    if ({msgIf.oMsgValid, msgIf.oMsgStatus, msgIf.oMsgNote, msgIf.oMsgVelocity} !== 25'h1902010) begin
      failures++;
      $display("FAIL overflow_head_stable got=%b_%02h%02h%02h required=1_902010", msgIf.oMsgValid,
               msgIf.oMsgStatus, msgIf.oMsgNote, msgIf.oMsgVelocity);
    end
    drainCheck("overflow");
  endtask

  task automatic test_reset_mid();
    stim = '{8'h90, 8'h3C};
    sendStim();
    stim = '{8'h90, 8'h3C, 8'h64};
    sendStim();
    gReset = 1'b0;
    @(negedge gClock);
    checks++;
    if ({msgIf.oMsgValid, oOverflow, oRunning, msgIf.oMsgStatus, msgIf.oMsgNote, msgIf.oMsgVelocity} !== 27'd0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b%b%b_%02h%02h%02h required=all_zero", msgIf.oMsgValid, oOverflow,
               oRunning, msgIf.oMsgStatus, msgIf.oMsgNote, msgIf.oMsgVelocity);
    end
    gReset = 1'b1;
    modelReset();
    stim = '{8'h64};
    sendStim();
    drainCheck("midreset");
  endtask

  function automatic logic [7:0] randByte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 8)  return 8'(248 + $urandom_range(0, 7));
    if (r < 14) return 8'(240 + $urandom_range(0, 7));
    if (r < 24) return 8'(128 + 16 * $urandom_range(0, 1) + $urandom_range(0, 3));
    if (r < 28) return 8'(160 + $urandom_range(0, 79));
    if (r < 36) return 8'h00;
    return 8'($urandom_range(0, 127));
  endfunction

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int len;
      len = $urandom_range(8, 18);
      for (int k = 0; k < len; k++) stim.push_back(randByte());
      sendStim();
      checks++;
      if (oRunning !== (mRun >= 0)) begin
        failures++; $display("FAIL random_running it=%0d got=%b required=%b", it, oRunning, mRun >= 0);
      end
      checks++;
      if (oOverflow !== mOvf) begin
        failures++; $display("FAIL random_overflow it=%0d got=%b required=%b", it, oOverflow, mOvf);
      end
      drainCheck("random");
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] act;
    logic [23:0] exp;
    logic [7:0]  b;
    msgIf.iMsgReady = 1'b1;
    for (int i = 0; i < 84; i++) begin
      @(negedge gClock);
      if (msgIf.oMsgValid) begin
        act = {msgIf.oMsgStatus, msgIf.oMsgNote, msgIf.oMsgVelocity};
        checks++;
        if (expQ.size() == 0) begin
          failures++; $display("FAIL b2b_unexpected got=%06h required=none", act);
        end else begin
          exp = expQ.pop_front();
          if (act !== exp) begin
            failures++; $display("FAIL b2b_msg got=%06h required=%06h", act, exp);
          end
        end
      end
      if (i < 80) begin
        b = (i % 13 == 0) ? 8'h94 : randByte();
        iByte = b; iByteValid = 1'b1;
        modelByte(b);
      end else begin
        iByteValid = 1'b0; iByte = 8'h00;
      end
    end
    msgIf.iMsgReady = 1'b0;
    checks++;
    if (expQ.size() != 0) begin
      failures++; $display("FAIL b2b_missing got=%0d_left required=0", expQ.size());
    end
    $display("back_to_back stream done");
  endtask

  initial begin
    msgIf.iMsgReady = 1'b0;
    test_reset();
    test_basic();
    test_running();
    test_realtime_vel0();
    test_abort_skip();
    test_overflow();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
